// File: rtl/muldiv_if.sv
// Request/result bundle between the issue logic and the multiply/divide unit.
// The issue side (master) presents one R-type request per cycle and watches
// req_ready; the unit (slave) returns HI/LO, the MFHI/MFLO result and a done pulse.
interface muldiv_if #(
   parameter int W = 32
);
   logic         req_valid;
   logic         req_ready;
   logic [5:0]   funct;
   logic [W-1:0] rrs;
   logic [W-1:0] rrt;
   logic [W-1:0] rslt;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         done;

   modport master (
      output req_valid, funct, rrs, rrt,
      input  req_ready, rslt, hi, lo, done
   );

   modport slave (
      input  req_valid, funct, rrs, rrt,
      output req_ready, rslt, hi, lo, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with its own HI/LO pair. Multiplies complete after a
// fixed latency; divides run a radix-2 restoring loop followed by a two-cycle
// sign fix-up. MTHI/MTLO/MFHI/MFLO complete at their issue edge.
module muldiv_unit #(
   parameter int W       = 32,
   parameter int MUL_LAT = 3
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   localparam int              CNT_W    = $clog2(W + MUL_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIX
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic [CNT_W-1:0] r_cnt;
   logic             r_fixStep;
   logic             r_mulSigned;
   logic             r_negQuot;
   logic             r_negRem;
   logic             r_divZero;
   logic             r_done;
   logic [W-1:0]     r_hi;
   logic [W-1:0]     r_lo;
   logic [W-1:0]     r_rslt;
   logic [W-1:0]     r_mulA;
   logic [W-1:0]     r_mulB;
   logic [W-1:0]     r_divisor;
   logic [W-1:0]     r_quot;
   logic [W-1:0]     r_rem;

   logic             w_busy;
   logic             w_accept;
   logic             w_isMul;
   logic             w_isDiv;
   logic             w_signedOp;
   logic             w_mulWrite;
   logic             w_divStep;
   logic             w_fixNeg;
   logic             w_fixWrite;
   logic [W-1:0]     w_absRs;
   logic [W-1:0]     w_absRt;
   logic [2*W-1:0]   w_mulAExt;
   logic [2*W-1:0]   w_mulBExt;
   logic [2*W-1:0]   w_product;
   logic [W:0]       w_shifted;
   logic [W:0]       w_trial;

   // Issue decode: requests are only taken while idle, so anything presented
   // during a multi-cycle operation simply falls on the floor.
   assign w_busy     = (r_state != IDLE);
   assign w_accept   = bus.req_valid && !w_busy;
   assign w_isMul    = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
   assign w_isDiv    = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
   assign w_signedOp = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);

   // The divider works on magnitudes; signs are reapplied in FIX.
   assign w_absRs = (w_signedOp && bus.rrs[W-1]) ? -bus.rrs : bus.rrs;
   assign w_absRt = (w_signedOp && bus.rrt[W-1]) ? -bus.rrt : bus.rrt;

   // Sign-extending to 2W bits lets one unsigned multiplier serve both forms.
   assign w_mulAExt = {{W{r_mulSigned & r_mulA[W-1]}}, r_mulA};
   assign w_mulBExt = {{W{r_mulSigned & r_mulB[W-1]}}, r_mulB};
   assign w_product = w_mulAExt * w_mulBExt;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and try subtracting the divisor. A zero divisor always
   // "succeeds", which yields an all-ones quotient and remainder = dividend.
   assign w_shifted = {r_rem, r_quot[W-1]};
   assign w_trial   = w_shifted - {1'b0, r_divisor};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and per-state datapath strobes. FIX spends one edge
   // negating the results and a second edge writing them to HI/LO, keeping the
   // negate adders out of the write path.
   always_comb begin
      w_nextState = r_state;
      w_mulWrite  = 1'b0;
      w_divStep   = 1'b0;
      w_fixNeg    = 1'b0;
      w_fixWrite  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && w_isMul) begin
               w_nextState = MUL;
            end else if (w_accept && w_isDiv) begin
               w_nextState = DIV;
            end
         end
         MUL: begin
            if (r_cnt == '0) begin
               w_mulWrite  = 1'b1;
               w_nextState = IDLE;
            end
         end
         DIV: begin
            w_divStep = 1'b1;
            if (r_cnt == '0) begin
               w_nextState = FIX;
            end
         end
         FIX: begin
            if (!r_fixStep) begin
               w_fixNeg = 1'b1;
            end else begin
               w_fixWrite  = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand capture, iteration counter, divide loop and sign fix-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_fixStep   <= 1'b0;
         r_mulSigned <= 1'b0;
         r_negQuot   <= 1'b0;
         r_negRem    <= 1'b0;
         r_divZero   <= 1'b0;
         r_mulA      <= '0;
         r_mulB      <= '0;
         r_divisor   <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
      end else begin
         if (w_accept && w_isMul) begin
            r_mulA      <= bus.rrs;
            r_mulB      <= bus.rrt;
            r_mulSigned <= w_signedOp;
            r_cnt       <= MUL_LOAD;
         end else if (w_accept && w_isDiv) begin
            r_quot    <= w_absRs;
            r_divisor <= w_absRt;
            r_rem     <= '0;
            r_negQuot <= w_signedOp && (bus.rrs[W-1] ^ bus.rrt[W-1]);
            r_negRem  <= w_signedOp && bus.rrs[W-1];
            r_divZero <= (bus.rrt == '0);
            r_cnt     <= DIV_LOAD;
         end else if ((r_state == MUL) || w_divStep) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_divStep) begin
            if (!w_trial[W]) begin
               r_rem  <= w_trial[W-1:0];
               r_quot <= {r_quot[W-2:0], 1'b1};
            end else begin
               r_rem  <= w_shifted[W-1:0];
               r_quot <= {r_quot[W-2:0], 1'b0};
            end
         end

         if (w_fixNeg) begin
            if (r_negQuot && !r_divZero) begin
               r_quot <= -r_quot;
            end
            if (r_negRem) begin
               r_rem <= -r_rem;
            end
         end

         r_fixStep <= w_fixNeg;
      end
   end

   // Architectural HI/LO, the MFHI/MFLO result register and the done pulse.
   // MFHI/MFLO sample the pre-edge HI/LO, so a same-edge move-to reads old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_rslt <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_mulWrite || w_fixWrite;

         if (w_accept && (bus.funct == FUNCT_MFHI)) begin
            r_rslt <= r_hi;
         end else if (w_accept && (bus.funct == FUNCT_MFLO)) begin
            r_rslt <= r_lo;
         end

         if (w_mulWrite) begin
            {r_hi, r_lo} <= w_product;
         end else if (w_fixWrite) begin
            r_hi <= r_rem;
            r_lo <= r_quot;
         end else if (w_accept && (bus.funct == FUNCT_MTHI)) begin
            r_hi <= bus.rrs;
         end else if (w_accept && (bus.funct == FUNCT_MTLO)) begin
            r_lo <= bus.rrs;
         end
      end
   end

   assign bus.req_ready = !w_busy;
   assign bus.rslt      = r_rslt;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a table of multiply/divide vectors
// with hand-derived HI/LO and latency, random vectors from a behavioural
// model, and hand-written sequences for move-to/from, busy and reset cases.
module tb_muldiv_unit;

   localparam int W       = 32;
   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = W + 2;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t vecs[11];

   muldiv_if #(.W(W)) bus();

   muldiv_unit #(.W(W), .MUL_LAT(MUL_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idleBus();
      bus.req_valid = 1'b0;
      bus.funct     = 6'h00;
      bus.rrs       = '0;
      bus.rrt       = '0;
   endtask

   // Present one request for a single edge; returns #1 after that edge.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.funct     = f;
      bus.rrs       = a;
      bus.rrt       = b;
      @(posedge clk);
      #1;
      idleBus();
   endtask

   // Count edges until done, checking the unit stays busy with HI/LO frozen.
   // With noise set, requests that must be ignored are presented meanwhile.
   task automatic waitDone(input bit noise, input logic [31:0] prevHi, input logic [31:0] prevLo,
                           output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 100) begin
         if (noise) begin
            if (lat < 8) begin
               bus.req_valid = 1'b1; bus.funct = F_MTLO; bus.rrs = 32'h1234; bus.rrt = '0;
            end else if (lat < 16) begin
               bus.req_valid = 1'b1; bus.funct = F_MULT; bus.rrs = 32'd3; bus.rrt = 32'd3;
            end else begin
               idleBus();
            end
         end
         @(posedge clk);
         #1;
         lat++;
         if (bus.done) begin
            ok = 1'b1;
         end else begin
            checkOutput("busy req_ready", {31'b0, bus.req_ready}, 32'd0);
            checkOutput("busy hi stable", bus.hi, prevHi);
            checkOutput("busy lo stable", bus.lo, prevLo);
         end
      end
      idleBus();
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL done timeout: got no done after %0d cycles expected one", lat);
      end
   endtask

   // Issue one multiply/divide, score it, then read LO back in the done cycle and HI after.
   task automatic runOp(input vec_t v, input bit noise);
      exp_t        e;
      logic [31:0] prevHi;
      logic [31:0] prevLo;
      int          lat;
      bit          ok;
      e.hi  = v.hi;
      e.lo  = v.lo;
      e.lat = v.lat;
      sbq.push_back(e);
      prevHi = bus.hi;
      prevLo = bus.lo;
      applyStimulus(v.funct, v.rs, v.rt);
      waitDone(noise, prevHi, prevLo, lat, ok);
      e = sbq.pop_front();
      if (ok) begin
         checkOutput({v.name, " latency"}, lat, e.lat);
         checkOutput({v.name, " hi"}, bus.hi, e.hi);
         checkOutput({v.name, " lo"}, bus.lo, e.lo);
         checkOutput({v.name, " ready in done cycle"}, {31'b0, bus.req_ready}, 32'd1);
         applyStimulus(F_MFLO, '0, '0);
         checkOutput({v.name, " mflo"}, bus.rslt, e.lo);
         checkOutput({v.name, " done one cycle"}, {31'b0, bus.done}, 32'd0);
         applyStimulus(F_MFHI, '0, '0);
         checkOutput({v.name, " mfhi"}, bus.rslt, e.hi);
      end
   endtask

   // Behavioural reference for random vectors (nonzero divisor, no overflow).
   function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output int lat);
      longint          sp;
      longint unsigned up;
      int              sa;
      int              sb;
      hi  = '0;
      lo  = '0;
      lat = DIV_LAT;
      sa  = a;
      sb  = b;
      case (f)
         F_MULT: begin
            sp       = longint'($signed(a)) * longint'($signed(b));
            {hi, lo} = sp;
            lat      = MUL_LAT;
         end
         F_MULTU: begin
            up       = 64'(a) * 64'(b);
            {hi, lo} = up;
            lat      = MUL_LAT;
         end
         F_DIV: begin
            lo = sa / sb;
            hi = sa % sb;
         end
         default: begin
            lo = a / b;
            hi = a % b;
         end
      endcase
   endfunction

   initial begin
      vec_t        rv;
      logic [5:0]  ops[4];
      bit          sawDone;
      logic [31:0] prevHi;
      logic [31:0] prevLo;

      ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

      vecs[0]  = '{"mult neg",       F_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
      vecs[1]  = '{"multu",          F_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MUL_LAT};
      vecs[2]  = '{"multu max",      F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
      vecs[3]  = '{"mult min sq",    F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
      vecs[4]  = '{"mult carry",     F_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT};
      vecs[5]  = '{"div neg",        F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
      vecs[6]  = '{"div neg divisor",F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
      vecs[7]  = '{"divu",           F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_LAT};
      vecs[8]  = '{"divu by zero",   F_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DIV_LAT};
      vecs[9]  = '{"div neg by zero",F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT};
      vecs[10] = '{"div overflow",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};

      idleBus();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset hi", bus.hi, 32'd0);
      checkOutput("reset lo", bus.lo, 32'd0);
      checkOutput("reset rslt", bus.rslt, 32'd0);
      checkOutput("reset done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset req_ready", {31'b0, bus.req_ready}, 32'd1);

      // Move-to / move-from, including rslt holding across a move-to.
      applyStimulus(F_MTHI, 32'h0000AAAA, '0);
      checkOutput("mthi hi", bus.hi, 32'h0000AAAA);
      checkOutput("mthi ready", {31'b0, bus.req_ready}, 32'd1);
      applyStimulus(F_MTLO, 32'h00005555, '0);
      checkOutput("mtlo lo", bus.lo, 32'h00005555);
      checkOutput("mtlo hi kept", bus.hi, 32'h0000AAAA);
      applyStimulus(F_MFHI, '0, '0);
      checkOutput("mfhi rslt", bus.rslt, 32'h0000AAAA);
      applyStimulus(F_MTLO, 32'h00007777, '0);
      checkOutput("rslt holds", bus.rslt, 32'h0000AAAA);
      applyStimulus(F_MFLO, '0, '0);
      checkOutput("mflo rslt", bus.rslt, 32'h00007777);
      checkOutput("no done for moves", {31'b0, bus.done}, 32'd0);

      // Table of multiply/divide vectors.
      for (int i = 0; i < 11; i++) begin
         runOp(vecs[i], 1'b0);
      end

      // Divide with ignored MTLO and MULT requests presented while busy.
      runOp('{"div busy", F_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, DIV_LAT}, 1'b1);

      // Unknown funct is ignored.
      prevHi = bus.hi;
      prevLo = bus.lo;
      applyStimulus(6'h2A, 32'hDEADBEEF, 32'd1);
      checkOutput("unknown ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("unknown hi", bus.hi, prevHi);
      checkOutput("unknown lo", bus.lo, prevLo);

      // Random vectors against the behavioural model.
      for (int i = 0; i < 6; i++) begin
         rv.name  = "random";
         rv.funct = ops[$urandom_range(3, 0)];
         rv.rs    = $urandom;
         rv.rt    = $urandom;
         if (i == 5) rv.rt = $urandom_range(9, 1);
         if (rv.rt == 32'd0) rv.rt = 32'd1;
         if (rv.rs == 32'h80000000 && rv.rt == 32'hFFFFFFFF) rv.rt = 32'd1;
         model(rv.funct, rv.rs, rv.rt, rv.hi, rv.lo, rv.lat);
         runOp(rv, 1'b0);
      end

      // Reset ten cycles into a divide: HI/LO clear and done never pulses.
      applyStimulus(F_MTHI, 32'h0BADF00D, '0);
      applyStimulus(F_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("mid reset hi", bus.hi, 32'd0);
      checkOutput("mid reset lo", bus.lo, 32'd0);
      checkOutput("mid reset ready", {31'b0, bus.req_ready}, 32'd1);
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) sawDone = 1'b1;
         @(posedge clk);
         #1;
      end
      checkOutput("mid reset no done", {31'b0, sawDone}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
